// File: rtl/ssd_pkg.sv
// ssd_pkg: shared types and constants for the seven-segment scan controller.
//   seg_t    : 7-bit active-low cathode vector {a,b,c,d,e,f,g}
//   SEG_OFF  : all cathodes released (segments dark)
//   HEX_SEG  : hex digit 0..F to active-low segment pattern
package ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'b1111111;

    localparam seg_t HEX_SEG [0:15] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/ssd_hex_decode.sv
// ssd_hex_decode: combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble : input  [3:0] hex digit
//   seg    : output [6:0] active-low cathodes {a,b,c,d,e,f,g}
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed common-anode seven-segment display scanner.
// Each digit owns a slot of SCAN_DIV clocks; the first BLANK_CYCLES of every
// slot keep all anodes off so the previous digit's pattern cannot ghost into
// the next one. Display data are captured into shadow registers only at the
// frame wrap, so a frame never shows a mix of old and new values.
// Optional build macro: SSD_DIM_EN adds a 4-bit brightness input that PWM-gates
// the anodes during the lit part of each slot.
// Ports:
//   clk        : system clock
//   Reset      : asynchronous, active-high reset
//   value_in   : hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   dp_in      : decimal point request per digit, active-high
//   digit_en   : per-digit enable, active-high
//   load       : one-cycle strobe requesting capture at the next frame wrap
//   bright     : (SSD_DIM_EN only) brightness, 15 = full, 0 = 1/16 duty
//   an         : anode enables, active-low
//   seg        : cathodes {a,b,c,d,e,f,g}, active-low
//   dp         : decimal point cathode, active-low
//   frame_tick : one-cycle pulse when the digit index wraps to 0
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
`ifdef SSD_DIM_EN
    input  logic [3:0]              bright,
`endif
    output logic [NUM_DIGITS-1:0]   an,
    output seg_t                    seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_en;
    logic                    load_pending;

    logic                    presc_tc;
    logic                    wrap;
    logic                    in_blank;
    logic [3:0]              cur_nib;
    seg_t                    dec_seg;
    logic [NUM_DIGITS-1:0]   onehot;
    logic                    lit_ok;

    assign presc_tc = (presc == PW'(SCAN_DIV - 1));
    assign wrap     = presc_tc && (idx == IW'(NUM_DIGITS - 1));
    assign in_blank = (presc < PW'(BLANK_CYCLES));
    assign cur_nib  = shadow_val[{idx, 2'b00} +: 4];
    assign onehot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

`ifdef SSD_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) pwm_cnt <= 4'd0;
        else       pwm_cnt <= pwm_cnt + 4'd1;
    end

    // pwm_cnt <= bright lights (bright+1) of every 16 cycles.
    assign lit_ok = (pwm_cnt <= bright);
`else
    assign lit_ok = 1'b1;
`endif

    ssd_hex_decode u_hex_decode (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            presc        <= '0;
            idx          <= '0;
            shadow_val   <= '0;
            shadow_dp    <= '0;
            shadow_en    <= '0;
            load_pending <= 1'b0;
            an           <= '1;
            seg          <= SEG_OFF;
            dp           <= 1'b1;
            frame_tick   <= 1'b0;
        end else begin
            presc <= presc_tc ? '0 : presc + 1'b1;
            if (presc_tc)
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

            frame_tick <= wrap;

            // A load landing on the wrap cycle itself is honoured at that wrap.
            if (wrap) begin
                if (load_pending || load) begin
                    shadow_val <= value_in;
                    shadow_dp  <= dp_in;
                    shadow_en  <= digit_en;
                end
                load_pending <= 1'b0;
            end else if (load) begin
                load_pending <= 1'b1;
            end

            if (in_blank) begin
                an  <= '1;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end else begin
                an  <= ~(onehot & shadow_en & {NUM_DIGITS{lit_ok}});
                seg <= shadow_en[idx] ? dec_seg : SEG_OFF;
                dp  <= ~(shadow_dp[idx] & shadow_en[idx]);
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed, table-driven bench for ssd_scan_ctrl with
// NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2 (32-cycle frame).
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] value_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  digit_en = 4'h0;
    logic        load = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;
`ifdef SSD_DIM_EN
    logic [3:0]  bright = 4'd15;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    // Posedges since reset release; used to predict the free-running PWM count.
    always @(posedge clk or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    ssd_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
`ifdef SSD_DIM_EN
        .bright     (bright),
`endif
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    typedef struct {
        logic [15:0]      value;
        logic [3:0]       en;
        logic [3:0]       dpi;
        logic [3:0][3:0]  an;   // expected anodes per digit slot
        logic [3:0][6:0]  seg;  // expected cathodes per digit slot
        logic [3:0]       dpo;  // expected dp per digit slot
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_tick();
        logic seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick) seen = 1'b1;
        end
        chk("wait_tick", {31'd0, seen}, 32'd1);
    endtask

    task automatic pulse_load(input int vi);
        @(negedge clk);
        value_in = tbl[vi].value;
        dp_in    = tbl[vi].dpi;
        digit_en = tbl[vi].en;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Starts on the cycle right after a frame_tick sample; checks 32 cycles
    // ending on the next frame_tick. Optionally issues a load mid-frame.
    task automatic run_frame(input int vi, input int load_at, input logic [15:0] nv);
        vec_t v;
        int d, p;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        v = tbl[vi];
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            if (j == load_at) begin
                value_in = nv;
                load     = 1'b1;
            end else begin
                load = 1'b0;
            end
            d = (j - 1) / 8;
            p = (j - 1) % 8;
            if (p < 2) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_an  = v.an[d];
                e_seg = v.seg[d];
                e_dp  = v.dpo[d];
`ifdef SSD_DIM_EN
                begin
                    logic [3:0] pw;
                    pw = 4'(cyc - 1);
                    if (pw > bright) e_an = 4'hF;
                end
`endif
            end
            chk($sformatf("vec%0d d%0d p%0d", vi, d, p),
                {19'd0, an, seg, dp, frame_tick},
                {19'd0, e_an, e_seg, e_dp, (j == 32)});
        end
    endtask

    initial begin
        tbl[0] = '{16'h3A9F, 4'b1111, 4'b0010,
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   {7'b0000110, 7'b0001000, 7'b0000100, 7'b0111000}, 4'b1101};
        tbl[1] = '{16'h0000, 4'b0101, 4'b1111,
                   {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                   {7'b1111111, 7'b0000001, 7'b1111111, 7'b0000001}, 4'b1010};
        tbl[2] = '{16'h1234, 4'b1111, 4'b0000,
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111};
        tbl[3] = '{16'hEDCB, 4'b1010, 4'b1000,
                   {4'b0111, 4'b1111, 4'b1101, 4'b1111},
                   {7'b0110000, 7'b1111111, 7'b0110001, 7'b1111111}, 4'b0111};
        tbl[4] = '{16'h6780, 4'b1111, 4'b0101,
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   {7'b0100000, 7'b0001111, 7'b0000000, 7'b0000001}, 4'b1010};
        tbl[5] = '{16'h5555, 4'b0001, 4'b1111,
                   {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                   {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100}, 4'b1110};
        tbl[6] = '{16'h0000, 4'b1111, 4'b0000,
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111};

        // Reset then idle: dark display, frame_tick every 32 cycles.
        repeat (3) @(negedge clk);
        chk("reset outputs", {20'd0, an, seg, dp, frame_tick}, {20'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
        Reset = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            chk($sformatf("idle k%0d", k), {20'd0, an, seg, dp, frame_tick},
                {20'd0, 4'hF, 7'h7F, 1'b1, (k % 32 == 0)});
        end

        // Table vectors: load, wait for the capturing wrap, check a full frame.
        for (int i = 0; i < 7; i++) begin
            pulse_load(i);
            wait_tick();
            run_frame(i, -1, 16'h0);
        end

        // Mid-frame load of 1234 while 0000 shows: current frame unchanged.
        run_frame(6, 12, 16'h1234);
        run_frame(2, -1, 16'h0);

        // Async reset during digit 2's lit part.
        repeat (20) @(negedge clk);
        chk("pre-reset an d2", {28'd0, an}, {28'd0, 4'b1011});
        #2 Reset = 1'b1;
        #1 chk("async reset", {20'd0, an, seg, dp, frame_tick}, {20'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        Reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            chk($sformatf("post-reset k%0d", k), {20'd0, an, seg, dp, frame_tick},
                {20'd0, 4'hF, 7'h7F, 1'b1, (k == 32)});
        end
        pulse_load(0);
        wait_tick();
        run_frame(0, -1, 16'h0);

`ifdef SSD_DIM_EN
        bright = 4'd3;
        run_frame(0, -1, 16'h0);
        bright = 4'd15;
        run_frame(0, -1, 16'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller for the board's 8-digit, common-anode SSD. It time-multiplexes NUM_DIGITS hex digits with per-digit enable and decimal point, and decodes 0-F to segments. Anti-ghosting blanking between digit slots and tear-free, frame-synchronous loading of display data are both built in. Instantiated in the top level in place of ad-hoc divided-clock scanning; runs on the 100 MHz system clock with no derived clocks.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..8).
SCAN_DIV, 100000, clk cycles per digit slot (>= 4).
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (must be < SCAN_DIV).

Ports:
clk  input  1  system clock, 100 MHz.
Reset  input  1  asynchronous, active-high reset.
value_in  input  4*NUM_DIGITS  hex nibbles; nibble i [4i+3:4i] drives digit i (digit 0 = rightmost, An0).
dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
digit_en  input  NUM_DIGITS  per-digit enable, active-high; 0 blanks that digit.
load  input  1  one-cycle strobe requesting capture of value_in/dp_in/digit_en.
an  output  NUM_DIGITS  anode enables, active-low.
seg  output  7  cathodes {Ca,Cb,Cc,Cd,Ce,Cf,Cg}, active-low.
dp  output  1  decimal point cathode, active-low.
frame_tick  output  1  one-cycle pulse when the digit index wraps to 0.

Behaviour:
- Reset (async, Reset=1): an all 1s; seg 7'b1111111; dp 1; frame_tick 0; prescaler 0; digit index 0; shadow value 0; shadow dp 0; shadow enables 0; load_pending 0.
- Prescaler counts 0..SCAN_DIV-1 and wraps. At the terminal count the digit index increments. The index wraps from NUM_DIGITS-1 to 0.
- frame_tick is asserted for exactly the single cycle in which the index wraps from NUM_DIGITS-1 to 0.
- Load handling is frame-synchronous:
  - A load pulse sets load_pending.
  - At the wrap cycle, if load_pending or load is 1, the shadow registers capture the current value_in, dp_in and digit_en, and load_pending clears.
  - A load coinciding with the wrap is captured at that same wrap. Multiple loads within one frame capture only the inputs present at the wrap.
- Outputs are registered and reflect the index and prescaler of the previous cycle (1-cycle latency).
- Within a slot, for prescaler < BLANK_CYCLES: an all 1s, seg all 1s, dp 1.
- Otherwise:
  - an = ~(onehot(index) & shadow_en).
  - seg = hexdecode(shadow nibble[index]), or all 1s if that digit is disabled.
  - dp = ~(shadow_dp[index] & shadow_en[index]).
- Hex decode (abcdefg, active-low):
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110
  - 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0000100, A 0001000, b 1100000
  - C 0110001, d 1000010, E 0110000, F 0111000
- Reset asserted mid-frame: immediate return to the reset state; scanning restarts at digit 0, prescaler 0.
- Because the shadow enables reset to 0, the display stays dark until the first load plus a frame wrap.

Optional Feature:
SSD_DIM_EN:
- Defined: adds input bright [3:0] and a free-running 4-bit pwm_cnt (reset 0, +1 per clk). In the non-blank part of a slot, an is additionally gated so a digit is lit only when pwm_cnt <= bright. bright=15 gives full on; bright=0 gives a 1/16 duty. seg and dp timing are unchanged.
- Undefined: no bright port, no pwm_cnt, full duty.

Decomposition:
- Package ssd_pkg:
  - SEG_OFF = 7'b1111111.
  - The 16-entry hex-to-segment constant table.
  - A typedef for the 7-bit segment vector.
- One natural sub-module: ssd_hex_decode (4-bit nibble in, 7-bit active-low segments out, combinational, uses the package table).
- Prescaler, index counter, shadow registers and output registers stay in ssd_scan_ctrl.

Test Plan:
Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
1. Reset then idle, no load -> an=4'b1111, seg=7'b1111111, dp=1 for 200 cycles; frame_tick pulses every 32 cycles.
2. load with value_in=16'h3A9F, digit_en=4'b1111, dp_in=4'b0010 -> after the next wrap:
   - digit0: an=1110, seg=0111000 (F)
   - digit1: an=1101, seg=0000100 (9), dp=0
   - digit2: seg=0001000 (A)
   - digit3: seg=0000110 (3)
   - the first 2 cycles of each slot are all-off.
3. load issued mid-frame with 16'h1234 while 16'h0000 is displayed -> remaining slots of the current frame still show 0 (seg=0000001); 1234 appears only from the next frame's digit 0.
4. digit_en=4'b0101 -> an[1] and an[3] never go low; seg=1111111 during their slots; digits 0 and 2 are lit normally.
5. Reset pulsed during digit 2's slot -> outputs go to reset values within the same cycle (async); after release, the first lit slot is digit 0, and only after a new load plus a wrap.
6. (SSD_DIM_EN) bright=4'd3, all digits enabled -> in each non-blank cycle, an is low only when pwm_cnt is 0..3; bright=15 -> low on every non-blank cycle.
